// File: rtl/legv8_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle LEGv8 datapath (shared memory and ALU).
// Sequences R-type, LDUR, STUR and CBZ; bounds memory waits; counts retired instructions.
module legv8_multicycle_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      OpCode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             PCSource,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             Reg2Loc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       Aluop,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_R_WB     = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_LD_WB    = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILL, CLS_R, CLS_LD, CLS_ST, CLS_CB
   } cls_t;

   state_t            state_q, state_d;
   cls_t              cls;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_hit;

   always_comb begin
      cls = CLS_ILL;
      casez (OpCode)
         11'b1??0101?000: cls = CLS_R;
         11'b11111000010: cls = CLS_LD;
         11'b11111000000: cls = CLS_ST;
         11'b10110100???: cls = CLS_CB;
         default:         cls = CLS_ILL;
      endcase
   end

   // mem_ready is sampled only in FETCH/MEM_RD/MEM_WR: a high cycle completes the
   // access; after TIMEOUT low cycles the next low cycle aborts (a high one still wins).
   assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT)) && !mem_ready;

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      Aluop       = 2'b00;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (cls)
               CLS_R:          state_d = S_EXEC_R;
               CLS_LD, CLS_ST: state_d = S_MEM_ADDR;
               CLS_CB:         state_d = S_BRANCH;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            Aluop   = 2'b10;
            state_d = S_R_WB;
         end
         S_R_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (cls == CLS_ST) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = S_LD_WB;
            end else if (timeout_hit) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_LD_WB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (timeout_hit) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            Aluop       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 1'b1;
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign Reg2Loc = (state_q != S_IDLE) && (state_q != S_FETCH) &&
                    ((cls == CLS_ST) || (cls == CLS_CB));

   // Any state change (including a timeout re-entering FETCH) restarts the wait count.
   always_comb begin
      wait_d = wait_q;
      if ((state_d != state_q) || mem_timeout) begin
         wait_d = '0;
      end else if (!mem_ready) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (instr_done && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the multi-cycle LEGv8 datapath. It uses a single shared memory and ALU, and steps through fetch, decode, execute, memory and write-back for ADD/SUB/AND/ORR, LDUR, STUR and CBZ. Memory accesses stall on a ready handshake and are bounded by a timeout. The block also keeps a saturating retired-instruction counter and flags illegal opcodes.

Parameters:
TIMEOUT, 15, maximum mem_ready wait cycles per access before abort.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
OpCode  in  11  instruction bits [31:21] from IR; valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
PCSource  out  1  0=ALU result, 1=ALUOut register
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
Reg2Loc  out  1  second read register select
ALUSrcA  out  1  0=old PC, 1=reg A
ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-ext offset, 11=branch offset<<2
Aluop  out  2  00=add, 01=pass-B/zero test, 10=funct decode
MemtoReg  out  1  write-back: 0=ALUOut, 1=MDR
RegWrite  out  1  register-file write
instr_done  out  1  one-cycle pulse on instruction retire
illegal_op  out  1  one-cycle pulse, unknown opcode in DECODE
mem_timeout  out  1  one-cycle pulse, access aborted
instr_count  out  CNT_W  retired instructions, saturates at all-ones
state  out  4  current state code for debug

Behaviour:
- Decode classes: R = 1xx0101x000; LDUR = 11111000010; STUR = 11111000000; CBZ = 10110100xxx; anything else is illegal.
- States and codes: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, R_WB 4, MEM_ADDR 5, MEM_RD 6, LD_WB 7, MEM_WR 8, BRANCH 9.
- Reset (async): state=IDLE, wait counter=0, instr_count=0. Every output is 0 in IDLE. IDLE goes to FETCH unconditionally on the next edge.
- All control outputs are combinational from state, except where qualified by mem_ready or OpCode as noted. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Aluop=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, Aluop=00 (target precompute into ALUOut).
  - Goes to EXEC_R, MEM_ADDR or BRANCH by class.
  - Illegal opcode: illegal_op=1 and return to FETCH. Not counted as retired.
- Reg2Loc = 1 whenever the OpCode class is STUR or CBZ, in every state except IDLE and FETCH (where it is 0).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, Aluop=10; goes to R_WB.
- R_WB: RegWrite=1, MemtoReg=0, instr_done=1; goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, Aluop=00; goes to MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MemRead=1, IorD=1; waits on mem_ready, then goes to LD_WB.
- LD_WB: RegWrite=1, MemtoReg=1, instr_done=1; goes to FETCH.
- MEM_WR: MemWrite=1, IorD=1; waits on mem_ready, then instr_done=1 and goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, Aluop=01, PCWriteCond=1, PCSource=1, instr_done=1; goes to FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle mem_ready=0 in those states.
  - If the count reaches TIMEOUT with mem_ready still 0: mem_timeout=1 that cycle, go to FETCH, no strobes asserted the following cycle beyond FETCH defaults, not counted.
  - mem_ready=1 on the same cycle as the timeout wins: the access completes normally.
- instr_count increments on every instr_done cycle and holds at 2^CNT_W-1.
- Zero-wait latency: R 4 cycles, LDUR 5, STUR 4, CBZ 3 (FETCH through retire).
- Reset asserted mid-instruction aborts immediately; no partial RegWrite/MemWrite after reset assertion.
- OpCode changes outside DECODE are ignored for transitions; OpCode only affects Reg2Loc and the MEM_ADDR branch choice.

Test Plan:
- Reset then mem_ready=1, OpCode=10001011000 (ADD): states 0,1,2,3,4,1; RegWrite=1 only in R_WB; instr_count=1 after 5 edges post-reset.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles with MemRead=1, IorD=1; then LD_WB with MemtoReg=1, RegWrite=1; instr_done pulses once.
- STUR 11111000000: Reg2Loc=1 in DECODE/MEM_ADDR/MEM_WR; MemWrite=1 only in MEM_WR; RegWrite never asserted; retire in 4 cycles.
- CBZ 10110100101: DECODE uses ALUSrcB=11; BRANCH has PCWriteCond=1, PCSource=1, Aluop=01; back in FETCH after 3 cycles.
- OpCode=00000000000: illegal_op pulses in DECODE, next state FETCH, instr_count unchanged.
- mem_ready held 0 in FETCH with TIMEOUT=15: mem_timeout pulses once after 15 waits, FSM re-enters FETCH; assert reset mid-MEM_WR: all outputs 0 the same cycle, state=0.
